apb_protocol_checker: RTL and testbench
=======================================

// Module: apb_protocol_checker
// PURPOSE
//  Synthesizable, parametrised APB3 bus monitor: passively samples one APB link, tracks protocol phase,
//  raises sticky per-rule violation flags and keeps saturating transfer/wait-state statistics.
//  Sits beside any APB master/slave pair (e.g. matrix-multiplier config port); drives nothing on the bus.
//  Replaces simulation-only property checks with hardware usable in FPGA/silicon debug.
// PARAMETERS
//  ADDR_W   3   paddr width
//  DATA_W   16  pwdata/prdata width
//  CNT_W    16  width of each statistics counter
//  TIMEOUT  16  max consecutive wait states before timeout violation (used only with APB_CHK_TIMEOUT_EN)
// PORTS
//  pclk        in   1        APB clock, all logic on posedge
//  preset_n    in   1        async active-low reset
//  psel        in   1        sampled bus select
//  penable     in   1        sampled bus enable
//  pwrite      in   1        sampled direction
//  paddr       in   ADDR_W   sampled address
//  pwdata      in   DATA_W   sampled write data
//  pready      in   1        sampled slave ready
//  clr         in   1        sync clear of flags, first_err and counters
//  err_flags   out  NUM_CHK  sticky violation flags, one bit per rule id
//  err_any     out  1        OR of err_flags
//  first_err   out  3        rule id of first violation since reset/clr; valid when err_any
//  phase       out  2        tracked phase of previous sample: IDLE=0 SETUP=1 WAIT=2 DONE=3
//  wr_cnt      out  CNT_W    completed writes, saturating
//  rd_cnt      out  CNT_W    completed reads, saturating
//  wait_cnt    out  CNT_W    total wait-state cycles, saturating
// BEHAVIOUR
//  Reset (async, preset_n=0): all outputs 0, phase=IDLE, captured ctrl regs 0.
//  Sample class each posedge: IDL=!psel; SET=psel&!penable; ACC=psel&penable; penable&!psel -> rule1, class IDL.
//  Legal transitions (else flag rule, then resync phase to current class):
//   IDLE->IDL|SET (ACC: rule1 PEN_NO_SETUP); SETUP->ACC only (else rule0 SETUP_NO_ACCESS);
//   WAIT->ACC only (else rule2 ACCESS_DROP); DONE->IDL|SET (ACC: rule3 PEN_AFTER_DONE).
//  Next phase: SET->SETUP; ACC&pready->DONE; ACC&!pready->WAIT; IDL->IDLE.
//  On SET: capture paddr, pwrite, pwdata. On ACC cycles following SETUP/WAIT: paddr or pwrite differ -> rule4
//   CTRL_UNSTABLE; captured pwrite=1 and pwdata differs -> rule5 WDATA_UNSTABLE. prdata is not checked.
//  Latency: flag/first_err/counters update at the posedge that samples the offending/complete cycle (1 reg stage).
//  ACC&pready: pwrite ? wr_cnt++ : rd_cnt++. ACC&!pready: wait_cnt++. All counters saturate at all-ones, no wrap.
//  Several rules in one cycle: all flags set; first_err takes lowest id if err_any was 0.
//  clr with simultaneous violation/completion: clear applied first, same-cycle event then recorded (error wins).
//  Reset mid-transfer: everything returns to reset state; next sample judged from IDLE.
// CONFIGURATION
//  APB_CHK_TIMEOUT_EN defined: consecutive-wait counter (clog2(TIMEOUT+1) bits) counts ACC&!pready cycles,
//   clears on any other class; reaching TIMEOUT sets rule6 TIMEOUT once per transfer (not re-flagged in same transfer).
//  Undefined: no counter logic; err_flags[6] tied 0; rest identical.
// STRUCTURE
//  apb_chk_pkg: phase_e enum (IDLE/SETUP/WAIT/DONE), rule id localparams CHK_SETUP_NO_ACCESS..CHK_TIMEOUT,
//   NUM_CHK=7 (constant, independent of macro).
//  Sub-module apb_sat_counter #(CNT_W): clr/inc, saturating; instantiated for wr_cnt, rd_cnt, wait_cnt.
// TESTING
//  Legal write 0x5<=0xBEEF, 2 waits, then read 0x2 no wait -> err_any=0, wr_cnt=1, rd_cnt=1, wait_cnt=2.
//  psel=1,penable=1 straight from idle -> err_flags[1]=1, first_err=1, phase=DONE/WAIT per pready.
//  SETUP at 0x3 then ACCESS with paddr=0x4 and pwdata changed on write -> err_flags[4]=1, [5]=1, first_err=4.
//  WAIT then psel=0 -> err_flags[2]=1; next cycle clr=1 -> flags, first_err, counters all 0.
//  Drive 2^CNT_W+3 reads -> rd_cnt holds 0xFFFF (CNT_W=16), no wrap.
//  With APB_CHK_TIMEOUT_EN, TIMEOUT=16: pready low 16 cycles -> err_flags[6]=1 once; without macro bit stays 0.

Source files
------------

// File: rtl/apb_chk_pkg.sv
// Shared types and rule identifiers for the APB3 protocol checker.
package apb_chk_pkg;

    // Tracked bus phase of the previously sampled cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } phase_e;

    // Rule ids; bit positions in err_flags.
    localparam int CHK_SETUP_NO_ACCESS = 0;
    localparam int CHK_PEN_NO_SETUP    = 1;
    localparam int CHK_ACCESS_DROP     = 2;
    localparam int CHK_PEN_AFTER_DONE  = 3;
    localparam int CHK_CTRL_UNSTABLE   = 4;
    localparam int CHK_WDATA_UNSTABLE  = 5;
    localparam int CHK_TIMEOUT         = 6;

    // Rule count is fixed so the flag vector width never depends on the build.
    localparam int NUM_CHK = 7;

    // Lowest-numbered rule present in a violation vector (0 when none).
    function automatic logic [2:0] lowest_rule(input logic [NUM_CHK-1:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/apb_sat_counter.sv
// Saturating event counter: synchronous clear takes effect first, then the
// same-cycle increment is applied; the value sticks at all-ones.
module apb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: clear-then-increment, hold at all-ones.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3 link monitor: tracks the transfer phase, raises sticky
// per-rule violation flags and keeps saturating transfer statistics.
// Optional build macro APB_CHK_TIMEOUT_EN adds the wait-state timeout rule;
// without it err_flags[6] stays 0.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_W-1:0]  paddr,
    input  logic [DATA_W-1:0]  pwdata,
    input  logic               pready,
    input  logic               clr,
    output logic [NUM_CHK-1:0] err_flags,
    output logic               err_any,
    output logic [2:0]         first_err,
    output logic [1:0]         phase,
    output logic [CNT_W-1:0]   wr_cnt,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [CNT_W-1:0]   wait_cnt
);

    phase_e              r_phase;
    phase_e              w_phase_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_CHK-1:0]  r_flags;
    logic                r_err_any;
    logic [2:0]          r_first;

    logic                w_set;
    logic                w_acc;
    logic                w_in_xfer;
    logic                w_to_hit;
    logic [NUM_CHK-1:0]  w_viol;
    logic [NUM_CHK-1:0]  w_flags_base;
    logic [NUM_CHK-1:0]  w_flags_nxt;
    logic [2:0]          w_first_nxt;

    assign w_set     = psel & ~penable;
    assign w_acc     = psel & penable;
    // ACCESS that continues a transfer begun in SETUP (or still waiting).
    assign w_in_xfer = w_acc & ((r_phase == SETUP) | (r_phase == WAIT));

`ifdef APB_CHK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_consec;

    // Fires only on the wait that reaches TIMEOUT; the counter then parks
    // there so the same transfer is never re-flagged.
    assign w_to_hit = w_acc & ~pready & (r_consec == TO_W'(TIMEOUT - 1));

    // Consecutive wait-state counter, cleared by any non-wait sample.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_consec <= '0;
        end else if (w_acc && !pready) begin
            r_consec <= (r_consec == TO_W'(TIMEOUT)) ? r_consec : r_consec + TO_W'(1);
        end else begin
            r_consec <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_to_hit         = 1'b0;
`endif

    // Per-rule violation detection for the current sample.
    always_comb begin
        w_viol = '0;
        w_viol[CHK_SETUP_NO_ACCESS] = (r_phase == SETUP) & ~w_acc;
        w_viol[CHK_PEN_NO_SETUP]    = (penable & ~psel) | ((r_phase == IDLE) & w_acc);
        w_viol[CHK_ACCESS_DROP]     = (r_phase == WAIT) & ~w_acc;
        w_viol[CHK_PEN_AFTER_DONE]  = (r_phase == DONE) & w_acc;
        w_viol[CHK_CTRL_UNSTABLE]   = w_in_xfer & ((paddr != r_addr) | (pwrite != r_write));
        w_viol[CHK_WDATA_UNSTABLE]  = w_in_xfer & r_write & (pwdata != r_wdata);
        w_viol[CHK_TIMEOUT]         = w_to_hit;
    end

    // Phase always resyncs to the class of the current sample.
    always_comb begin
        w_phase_nxt = IDLE;
        if (w_set) begin
            w_phase_nxt = SETUP;
        end else if (w_acc && pready) begin
            w_phase_nxt = DONE;
        end else if (w_acc) begin
            w_phase_nxt = WAIT;
        end else begin
            w_phase_nxt = IDLE;
        end
    end

    // Sticky flags with clear-first semantics; first_err latches lowest new id.
    always_comb begin
        w_flags_base = clr ? '0 : r_flags;
        w_flags_nxt  = w_flags_base | w_viol;
        w_first_nxt  = r_first;
        if (!(|w_flags_base) && (|w_viol)) begin
            w_first_nxt = lowest_rule(w_viol);
        end else if (clr) begin
            w_first_nxt = 3'd0;
        end else begin
            w_first_nxt = r_first;
        end
    end

    // Phase state register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_phase <= IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Capture control and write data at the SETUP sample.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_set) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
        end else begin
            r_addr  <= r_addr;
            r_write <= r_write;
            r_wdata <= r_wdata;
        end
    end

    // Error reporting registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_flags   <= '0;
            r_err_any <= 1'b0;
            r_first   <= 3'd0;
        end else begin
            r_flags   <= w_flags_nxt;
            r_err_any <= |w_flags_nxt;
            r_first   <= w_first_nxt;
        end
    end

    apb_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clr      (clr),
        .inc      (w_acc & pready & pwrite),
        .cnt      (wr_cnt)
    );

    apb_sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clr      (clr),
        .inc      (w_acc & pready & ~pwrite),
        .cnt      (rd_cnt)
    );

    apb_sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clr      (clr),
        .inc      (w_acc & ~pready),
        .cnt      (wait_cnt)
    );

    assign err_flags = r_flags;
    assign err_any   = r_err_any;
    assign first_err = r_first;
    assign phase     = r_phase;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Scoreboard bench for apb_protocol_checker: the driver feeds one bus sample
// per cycle into a rule-level reference model and queues the expected
// outputs; a monitor pops and compares after every clock edge.
module tb_apb_protocol_checker;

    localparam int CW   = 12;
    localparam int TO   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pready = 1'b0, clr = 1'b0;
    logic [2:0]    paddr = 3'd0;
    logic [15:0]   pwdata = 16'd0;
    logic [6:0]    err_flags;
    logic          err_any;
    logic [2:0]    first_err;
    logic [1:0]    phase;
    logic [CW-1:0] wr_cnt, rd_cnt, wait_cnt;

    always #5 pclk = ~pclk;

    apb_protocol_checker #(.ADDR_W(3), .DATA_W(16), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
        .clr(clr), .err_flags(err_flags), .err_any(err_any), .first_err(first_err),
        .phase(phase), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .wait_cnt(wait_cnt)
    );

    typedef struct {
        logic [6:0] flags;
        logic       any;
        int         first;
        int         ph;
        int         wr;
        int         rd;
        int         wt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model state (rule level: where we are in a transfer).
    int         m_ph;       // 0 idle, 1 setup seen, 2 waiting, 3 just completed
    logic [6:0] m_flags;
    int         m_first, m_wr, m_rd, m_wt, m_consec;
    logic [2:0] m_a;
    logic       m_w;
    logic [15:0] m_d;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_flags = '0; m_first = 0; m_wr = 0; m_rd = 0; m_wt = 0;
        m_consec = 0; m_a = '0; m_w = 1'b0; m_d = '0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_step(input logic rst, input logic sel, input logic en, input logic wr,
                              input logic [2:0] a, input logic [15:0] d, input logic rdy,
                              input logic c);
        logic [6:0] v;
        bit acc, setc;
        if (!rst) begin
            model_reset();
            return;
        end
        v = '0;
        acc  = sel && en;
        setc = sel && !en;
        if (en && !sel) v[1] = 1'b1;
        if (m_ph == 0 && acc)  v[1] = 1'b1;
        if (m_ph == 1 && !acc) v[0] = 1'b1;
        if (m_ph == 2 && !acc) v[2] = 1'b1;
        if (m_ph == 3 && acc)  v[3] = 1'b1;
        if (acc && (m_ph == 1 || m_ph == 2)) begin
            if (a != m_a || wr != m_w) v[4] = 1'b1;
            if (m_w && d != m_d) v[5] = 1'b1;
        end
`ifdef APB_CHK_TIMEOUT_EN
        if (acc && !rdy) begin
            if (m_consec == TO - 1) v[6] = 1'b1;
            if (m_consec < TO) m_consec++;
        end else begin
            m_consec = 0;
        end
`endif
        if (c) begin
            m_flags = '0; m_first = 0; m_wr = 0; m_rd = 0; m_wt = 0;
        end
        if (m_flags == 0 && v != 0) begin
            for (int i = 6; i >= 0; i--) if (v[i]) m_first = i;
        end
        m_flags = m_flags | v;
        if (acc && rdy) begin
            if (wr) m_wr = sat_inc(m_wr);
            else    m_rd = sat_inc(m_rd);
        end
        if (acc && !rdy) m_wt = sat_inc(m_wt);
        if (setc) begin
            m_a = a; m_w = wr; m_d = d;
        end
        m_ph = setc ? 1 : (acc ? (rdy ? 3 : 2) : 0);
    endtask

    task automatic drive(input logic rst, input logic sel, input logic en, input logic wr,
                         input logic [2:0] a, input logic [15:0] d, input logic rdy,
                         input logic c);
        exp_t e;
        @(negedge pclk);
        preset_n = rst; psel = sel; penable = en; pwrite = wr;
        paddr = a; pwdata = d; pready = rdy; clr = c;
        model_step(rst, sel, en, wr, a, d, rdy, c);
        e.flags = m_flags; e.any = (m_flags != 0); e.first = m_first; e.ph = m_ph;
        e.wr = m_wr; e.rd = m_rd; e.wt = m_wt;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    endtask

    // Legal transfer with a given number of wait states.
    task automatic xfer(input logic wr, input logic [2:0] a, input logic [15:0] d, input int waits);
        drive(1'b1, 1'b1, 1'b0, wr, a, d, 1'b0, 1'b0);
        for (int i = 0; i < waits; i++) drive(1'b1, 1'b1, 1'b1, wr, a, d, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, wr, a, d, 1'b1, 1'b0);
    endtask

    // Wait until the sample just driven has been clocked in.
    task automatic settle();
        @(posedge pclk);
        #2;
    endtask

    // Monitor: compare every clocked output against the queued expectation.
    always @(posedge pclk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("err_flags", int'(err_flags), int'(e.flags));
            chk("err_any",   int'(err_any),   int'(e.any));
            chk("first_err", int'(first_err), e.first);
            chk("phase",     int'(phase),     e.ph);
            chk("wr_cnt",    int'(wr_cnt),    e.wr);
            chk("rd_cnt",    int'(rd_cnt),    e.rd);
            chk("wait_cnt",  int'(wait_cnt),  e.wt);
        end
    end

    initial begin
        int exp6;
        int budget;
        model_reset();
        // Reset
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0);
        settle();
        chk("reset_flags", int'(err_flags), 0);
        chk("reset_phase", int'(phase), 0);
        chk("reset_wr", int'(wr_cnt), 0);
        idle(2);

        // Legal write with two waits, then read with none
        xfer(1'b1, 3'd5, 16'hBEEF, 2);
        xfer(1'b0, 3'd2, 16'd0, 0);
        settle();
        chk("legal_err_any", int'(err_any), 0);
        chk("legal_wr", int'(wr_cnt), 1);
        chk("legal_rd", int'(rd_cnt), 1);
        chk("legal_wait", int'(wait_cnt), 2);
        idle(1);

        // ACCESS straight from idle
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 16'd0, 1'b1, 1'b0);
        settle();
        chk("pen_no_setup_flag", int'(err_flags[1]), 1);
        chk("pen_no_setup_first", int'(first_err), 1);
        chk("pen_no_setup_phase", int'(phase), 3);
        idle(1);
        do_clr();

        // Unstable control and write data
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 16'h5678, 1'b1, 1'b0);
        settle();
        chk("unstable_flags45", int'(err_flags[5:4]), 3);
        chk("unstable_first", int'(first_err), 4);
        idle(1);
        do_clr();

        // Access dropped while waiting, then clear
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 16'd0, 1'b0, 1'b0);
        settle();
        chk("access_drop_flag", int'(err_flags[2]), 1);
        do_clr();
        settle();
        chk("clr_flags", int'(err_flags), 0);
        chk("clr_wait", int'(wait_cnt), 0);

        // Reset in the middle of a transfer
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b1, 1'b0);
        idle(1);
        do_clr();

        // Read counter saturation
        for (int i = 0; i < MAXC + 4; i++) xfer(1'b0, 3'd1, 16'd0, 0);
        settle();
        chk("rd_saturate", int'(rd_cnt), MAXC);
        idle(1);
        do_clr();

        // Wait-state timeout
        xfer(1'b0, 3'd0, 16'd0, TO + 3);
        settle();
`ifdef APB_CHK_TIMEOUT_EN
        exp6 = 1;
`else
        exp6 = 0;
`endif
        chk("timeout_flag", int'(err_flags[6]), exp6);
        idle(1);
        do_clr();

        // Randomised transfers with occasional corruption, clears and resets
        for (int t = 0; t < 1500; t++) begin
            logic       w;
            logic [2:0] a;
            logic [15:0] d;
            int waits;
            w = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                drive(1'($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                      3'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
            end else begin
                drive(1'b1, 1'b1, 1'b0, w, a, d, 1'b0, 1'($urandom_range(0, 15) == 0));
                for (int i = 0; i < waits; i++) drive(1'b1, 1'b1, 1'b1, w, a, d, 1'b0, 1'b0);
                drive(1'b1, 1'b1, 1'b1, w, a, d, 1'b1, 1'($urandom_range(0, 15) == 0));
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge pclk);
            budget--;
        end
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
